seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked execution unit that replaces the purely combinational ALU in the multi-cycle and pipelined cores. It performs WIDTH-bit add/sub/with-carry, logic ops and an iterative unsigned multiply producing a 2·WIDTH product. It reports ARM-style NZCV flags. Operands enter through a valid/ready input port and results leave through a registered valid/ready output port, so the control unit can stall on multiply without a separate busy protocol.

## Interface
- WIDTH, 32, datapath width in bits; legal range 4–64.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and Op are valid this cycle
- in_ready  out  1  unit accepts an operation this cycle
- SrcA, SrcB  in  WIDTH  operands
- Op  in  4  operation code (see Operation)
- carry  in  1  C flag input, used by ADC and SBC
- out_valid  out  1  Result, ResultHi, ALUFlags and illegal are valid
- out_ready  in  1  consumer takes the result this cycle
- Result  out  WIDTH  result; low half of the product for MUL
- ResultHi  out  WIDTH  high half of the product for MUL; 0 for all other ops
- ALUFlags  out  4  {N, Z, C, V}
- illegal  out  1  reserved Op was executed

## Operation
- Op codes:
  - 0000 ADD: A+B
  - 0001 SUB: A+~B+1
  - 0100 ADC: A+B+carry
  - 0101 SBC: A+~B+carry
  - 0010 AND: A&B
  - 0011 ORR: A|B
  - 0110 EOR: A^B
  - 0111 BIC: A&~B
  - 1000 MUL: unsigned A·B
  - 1001–1111: reserved
- Arithmetic ops use a (WIDTH+1)-bit sum.
  - C = sum[WIDTH].
  - V = ~(A[W-1]^B[W-1]^Op[0]) & (A[W-1]^sum[W-1]).
- Logic ops, MUL and reserved codes force C=0 and V=0.
- N = Result[W-1] and Z = (Result==0) for every op. For MUL, N and Z are computed on the low half only.
- Reserved codes: Result=0, ResultHi=0, flags 0100 (Z=1, from the N/Z rule), illegal=1. They complete in one cycle.
- illegal is 0 for all defined ops.
- All input fields, including carry, are sampled only on the accept edge (in_valid & in_ready). They are ignored at all other times.
- FSM states:
  - IDLE: single-cycle ops execute on the accept edge. A MUL accept goes to MUL_RUN.
  - MUL_RUN: shift-add, one multiplier bit per edge, with a counter from 0 to WIDTH-1. The last iteration writes the output registers and returns to IDLE.
- in_ready = (state==IDLE) & (~out_valid | out_ready). It is combinational from registered state and out_ready.
- Output registers load only on op completion and hold while out_valid & ~out_ready.
- out_valid:
  - Sets on completion.
  - Clears on an edge with out_ready=1 and no new completion.
  - A simultaneous drain and completion keeps out_valid=1 with the new data.
- A MUL is accepted only when the output slot is free or draining, so a MUL completion never collides with an undrained result.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, counter=0, out_valid=0, Result=0, ResultHi=0, ALUFlags=0000, illegal=0.
  - in_ready=1 in the first cycle after reset.
- Single-cycle ops have 1-cycle latency. out_valid is high in the cycle after the accept edge.
  - Throughput is 1 op/cycle with out_ready held high.
- MUL has WIDTH-cycle latency. With the accept edge at t0, out_valid is high after edge t0+WIDTH.
  - in_ready=0 from after t0 until that completion edge. in_ready can return to 1 in the same cycle out_valid rises, if out_ready=1.
- Reset asserted mid-MUL aborts the multiply and discards it; no result is produced.
- in_valid=1 while in_ready=0: nothing is accepted, and the inputs may change freely.
- out_ready with out_valid=0: no effect.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> Result 0x80000000, NZCV 1001, out_valid one cycle after accept.
- SUB 5-5 -> Result 0, NZCV 0110.
- SBC 5-3 with carry=0 -> Result 1, NZCV 0010.
- BIC 0xFF00FF00,0x0F0F0F0F -> 0xF000F000, NZCV 1000.
- Op 1010 -> illegal=1, Result 0, NZCV 0100.
- MUL 0xFFFFFFFF·0xFFFFFFFF -> Result 0x00000001, ResultHi 0xFFFFFFFE, NZCV 0000.
  - out_valid rises exactly 32 edges after accept.
  - in_ready=0 throughout the multiply.
- Backpressure: issue ADD, hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0 for those cycles. Then out_ready=1 with in_valid=1 -> drain and accept on the same edge, back-to-back results.
- Reset mid-MUL at iteration 10 -> all outputs reset values, state IDLE. The next ADD 2+3 -> 5 with 1-cycle latency.
- WIDTH=8 instance: ADD 0xFF+0x01 -> 0x00, NZCV 0110.
  - MUL 0x0F·0x11 -> Result 0xFF, ResultHi 0x00, latency 8.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked execution unit: single-cycle add/sub/logic ops and an iterative
// shift-add unsigned multiply, with NZCV flags and a registered valid/ready result.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       Op,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       ALUFlags,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_ADC = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_EOR = 4'b0110;
  localparam logic [3:0] OP_BIC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;

  logic             accept, is_mul, mul_last;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  logic             done;
  logic [WIDTH-1:0] done_res, done_hi;
  logic             done_c, done_v, done_ill;

  assign in_ready = (state == S_IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (Op == OP_MUL);
  assign mul_last = (state == S_MUL_RUN) && (cnt == LAST);

  // One multiplier bit per edge: add the multiplicand into the high half when the
  // current LSB is set, then shift the whole {hi, lo} product right by one.
  assign step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi   = step_sum[WIDTH:1];
  assign mul_lo   = {step_sum[0], acc_lo[WIDTH-1:1]};

  // Subtract forms invert B; ADC/SBC take the external carry, ADD/SUB use Op[0].
  assign b_eff = Op[0] ? ~SrcB : SrcB;
  assign cin   = Op[2] ? carry : Op[0];
  assign sum   = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept && is_mul) state_nxt = S_MUL_RUN;
      S_MUL_RUN: if (mul_last)         state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (Op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(SrcA[WIDTH-1] ^ SrcB[WIDTH-1] ^ Op[0]) & (SrcA[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND:  alu_res = SrcA & SrcB;
      OP_ORR:  alu_res = SrcA | SrcB;
      OP_EOR:  alu_res = SrcA ^ SrcB;
      OP_BIC:  alu_res = SrcA & ~SrcB;
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // A MUL can only finish in MUL_RUN and an accept only happens in IDLE, so the
  // two completion sources never coincide.
  always_comb begin
    done     = 1'b0;
    done_res = alu_res;
    done_hi  = '0;
    done_c   = alu_c;
    done_v   = alu_v;
    done_ill = alu_ill;
    if (mul_last) begin
      done     = 1'b1;
      done_res = mul_lo;
      done_hi  = mul_hi;
      done_c   = 1'b0;
      done_v   = 1'b0;
      done_ill = 1'b0;
    end else if (accept && !is_mul) begin
      done = 1'b1;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept && is_mul) begin
      cnt    <= '0;
      mcand  <= SrcA;
      acc_hi <= '0;
      acc_lo <= SrcB;
    end else if (state == S_MUL_RUN) begin
      cnt    <= mul_last ? '0 : cnt + CW'(1);
      acc_hi <= mul_hi;
      acc_lo <= mul_lo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      Result    <= '0;
      ResultHi  <= '0;
      ALUFlags  <= '0;
      illegal   <= 1'b0;
    end else if (done) begin
      out_valid <= 1'b1;
      Result    <= done_res;
      ResultHi  <= done_hi;
      ALUFlags  <= {done_res[WIDTH-1], done_res == '0, done_c, done_v};
      illegal   <= done_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: 32-bit and 8-bit instances, directed vectors plus
// randomized traffic with backpressure, checked against an arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        in_valid0, in_ready0, carry0, out_valid0, out_ready0, illegal0;
  logic [31:0] a0, b0, res0, hi0;
  logic [3:0]  op0, flags0;

  logic        in_valid1, in_ready1, carry1, out_valid1, out_ready1, illegal1;
  logic [7:0]  a1, b1, res1, hi1;
  logic [3:0]  op1, flags1;

  seq_alu #(.WIDTH(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .SrcA(a0), .SrcB(b0), .Op(op0), .carry(carry0), .out_valid(out_valid0),
    .out_ready(out_ready0), .Result(res0), .ResultHi(hi0), .ALUFlags(flags0),
    .illegal(illegal0)
  );

  seq_alu #(.WIDTH(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .SrcA(a1), .SrcB(b1), .Op(op1), .carry(carry1), .out_valid(out_valid1),
    .out_ready(out_ready1), .Result(res1), .ResultHi(hi1), .ALUFlags(flags1),
    .illegal(illegal1)
  );

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic [3:0]  flags;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   bp_mode = 1'b0;
  bit   prev_v[2];
  bit   prev_x[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @cyc %0d: timed out", name, cyc);
  endtask

  // Reference: plain integer arithmetic; V from the true signed result range.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] op, input logic cin);
    exp_t        e;
    logic [63:0] mask, s, p;
    longint      sa, sb, full, lim;
    bit          arith;
    mask  = (64'd1 << w) - 64'd1;
    sa    = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb    = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    lim   = longint'(1) << (w - 1);
    e     = '{res: 64'd0, hi: 64'd0, flags: 4'd0, ill: 1'b0, due: 0};
    arith = 1'b0;
    s     = 64'd0;
    full  = 0;
    case (op)
      4'd0: begin arith = 1'b1; s = a + b;                      full = sa + sb; end
      4'd1: begin arith = 1'b1; s = a + (~b & mask) + 64'd1;    full = sa - sb; end
      4'd4: begin arith = 1'b1; s = a + b + 64'(cin);           full = sa + sb + longint'(cin); end
      4'd5: begin arith = 1'b1; s = a + (~b & mask) + 64'(cin); full = sa - sb - 1 + longint'(cin); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd6: e.res = a ^ b;
      4'd7: e.res = a & ~b & mask;
      4'd8: begin p = a * b; e.res = p & mask; e.hi = p >> w; end
      default: e.ill = 1'b1;
    endcase
    if (arith) begin
      e.res      = s & mask;
      e.flags[1] = s[w];
      e.flags[0] = (full < -lim) || (full > lim - 1);
    end
    e.flags[3] = e.res[w-1];
    e.flags[2] = (e.res == 64'd0);
    return e;
  endfunction

  task automatic issue_core(input int inst, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] op, input logic c, input exp_t e);
    bit got   = 1'b0;
    int guard = 0;
    if (inst == 0) begin
      in_valid0 = 1'b1; a0 = a[31:0]; b0 = b[31:0]; op0 = op; carry0 = c;
    end else begin
      in_valid1 = 1'b1; a1 = a[7:0];  b1 = b[7:0];  op1 = op; carry1 = c;
    end
    while (!got && guard < 200) begin
      @(negedge clk);
      if ((inst == 0) ? in_ready0 : in_ready1) got = 1'b1;
      else guard++;
    end
    if (got) begin
      e.due = cyc + 1 + ((op == 4'd8) ? ((inst == 0) ? 32 : 8) : 0);
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end else begin
      fail_now("accept_wait");
    end
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge: only the accepted values may matter.
    if (inst == 0) begin
      in_valid0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 4'($urandom); carry0 = 1'($urandom);
    end else begin
      in_valid1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); op1 = 4'($urandom); carry1 = 1'($urandom);
    end
  endtask

  task automatic issue(input int inst, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] op, input logic c);
    issue_core(inst, a, b, op, c, model((inst == 0) ? 32 : 8, a, b, op, c));
  endtask

  task automatic issue_k(input int inst, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic c, input logic [63:0] r,
                         input logic [63:0] h, input logic [3:0] f, input logic il);
    exp_t e;
    e = '{res: r, hi: h, flags: f, ill: il, due: 0};
    issue_core(inst, a, b, op, c, e);
  endtask

  task automatic mon(input int inst, input logic v, input logic r, input logic [63:0] res,
                     input logic [63:0] hi, input logic [3:0] f, input logic il);
    exp_t h;
    bit   empty;
    if (v) begin
      empty = (inst == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result inst%0d @cyc %0d: got %0h, expected none", inst, cyc, res);
      end else begin
        h = (inst == 0) ? q0[0] : q1[0];
        if (!prev_v[inst] || prev_x[inst]) check($sformatf("latency%0d", inst), 64'(cyc), 64'(h.due));
        check($sformatf("result%0d", inst),  res,      h.res);
        check($sformatf("resulthi%0d", inst), hi,      h.hi);
        check($sformatf("flags%0d", inst),   64'(f),   64'(h.flags));
        check($sformatf("illegal%0d", inst), 64'(il),  64'(h.ill));
        if (r) begin
          if (inst == 0) void'(q0.pop_front());
          else           void'(q1.pop_front());
        end
      end
    end
    prev_v[inst] = v;
    prev_x[inst] = v && r;
  endtask

  always @(negedge clk) mon(0, out_valid0, out_ready0, 64'(res0), 64'(hi0), flags0, illegal0);
  always @(negedge clk) mon(1, out_valid1, out_ready1, 64'(res1), 64'(hi1), flags1, illegal1);

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready0 = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [63:0] rand_val(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8};
    logic [3:0] op;
    int         r;
    bit         drained;

    reset_n = 1'b0;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; op0 = '0; carry0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; carry1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_result",    64'(res0),       64'd0);
    check("rst_resulthi",  64'(hi0),        64'd0);
    check("rst_flags",     64'(flags0),     64'd0);
    check("rst_illegal",   64'(illegal0),   64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready0), 64'd1);

    // Back-to-back single-cycle vectors with known answers.
    issue_k(0, 64'h7FFF_FFFF, 64'h1, 4'b0000, 1'b0, 64'h8000_0000, 64'd0, 4'b1001, 1'b0);
    issue_k(0, 64'd5, 64'd5, 4'b0001, 1'b0, 64'd0, 64'd0, 4'b0110, 1'b0);
    issue_k(0, 64'd5, 64'd3, 4'b0101, 1'b0, 64'd1, 64'd0, 4'b0010, 1'b0);
    issue_k(0, 64'hFF00_FF00, 64'h0F0F_0F0F, 4'b0111, 1'b0, 64'hF000_F000, 64'd0, 4'b1000, 1'b0);
    issue_k(0, 64'd123, 64'd456, 4'b1010, 1'b1, 64'd0, 64'd0, 4'b0100, 1'b1);

    issue_k(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'b1000, 1'b0, 64'd1, 64'hFFFF_FFFE, 4'b0000, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("mul_in_ready_low", 64'(in_ready0), 64'd0);
    end
    @(negedge clk);
    check("mul_done_valid",    64'(out_valid0), 64'd1);
    check("mul_done_in_ready", 64'(in_ready0),  64'd1);
    @(posedge clk);
    #1;

    // Backpressure: result must hold and block new work until drained.
    out_ready0 = 1'b0;
    issue_k(0, 64'd10, 64'd20, 4'b0000, 1'b0, 64'd30, 64'd0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready0),  64'd0);
      check("bp_valid",    64'(out_valid0), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready0 = 1'b1;
    issue_k(0, 64'd1, 64'd1, 4'b0000, 1'b0, 64'd2, 64'd0, 4'b0000, 1'b0);

    // Reset in the middle of a multiply discards it.
    issue(0, 64'h1234_5678, 64'h9ABC_DEF0, 4'b1000, 1'b0);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid0), 64'd0);
    check("midrst_result",    64'(res0),       64'd0);
    check("midrst_resulthi",  64'(hi0),        64'd0);
    check("midrst_flags",     64'(flags0),     64'd0);
    check("midrst_in_ready",  64'(in_ready0),  64'd1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", 64'(in_ready0), 64'd1);
    issue_k(0, 64'd2, 64'd3, 4'b0000, 1'b0, 64'd5, 64'd0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("postrst_no_stray", 64'(out_valid0), 64'd0);

    // 8-bit instance corner cases.
    issue_k(1, 64'hFF, 64'h01, 4'b0000, 1'b0, 64'h00, 64'd0, 4'b0110, 1'b0);
    issue_k(1, 64'h0F, 64'h11, 4'b1000, 1'b0, 64'hFF, 64'h00, 4'b1000, 1'b0);
    repeat (12) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure on both instances.
    bp_mode = 1'b1;
    for (int inst = 0; inst < 2; inst++) begin
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        r = $urandom_range(0, 10);
        op = (r < 9) ? ops[r] : 4'($urandom_range(9, 15));
        issue(inst, rand_val((inst == 0) ? 32 : 8), rand_val((inst == 0) ? 32 : 8),
              op, 1'($urandom));
      end
    end

    bp_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 100 && !drained; i++) begin
      @(negedge clk);
      drained = (q0.size() == 0) && (q1.size() == 0);
    end
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
